// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer:
// opcodes, state codes and the datapath mux select values.
package mips_ctrl_pkg;

  // IR[31:26] values the sequencer understands
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Codes 13-15 are unused and fall back to IDLE
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_REGB    = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // True when the opcode maps to an instruction this build executes
  function automatic logic op_supported(input logic [5:0] op, input logic addiEn);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_supported = 1'b1;
      OP_ADDI:                             op_supported = addiEn;
      default:                             op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
//
// Handshake: the sequencer holds MemRead or MemWrite (with IorD) steady
// while it waits; memReady high in a cycle means the access completes on
// that clock edge. There is no separate request/valid pulse -- the strobe
// itself is the request, and it drops in the cycle after memReady.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       memReady;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic       RegDst;

  modport master (
    input  opcode, memReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst
  );

  modport slave (
    output opcode, memReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style sequencer for the multicycle MIPS datapath. Outputs decode
// from the state register (plus memReady in the memory-wait states), so an
// asynchronous reset forces every control line to 0 straight away.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter int STATE_W     = 4      // must be at least 4
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_control_if.master ctrl,
  output logic [STATE_W-1:0] state,
  output logic               illegalOp
);

  state_t cur;

  // State register and next-state selection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_IDLE;
    end else begin
      case (cur)
        S_IDLE:      cur <= S_FETCH;
        S_FETCH:     cur <= ctrl.memReady ? S_DECODE : S_FETCH;
        S_DECODE: begin
          if (!op_supported(ctrl.opcode, ENABLE_ADDI)) begin
            cur <= S_FETCH;
          end else begin
            case (ctrl.opcode)
              OP_RTYPE:     cur <= S_R_EXEC;
              OP_LW, OP_SW: cur <= S_MEM_ADDR;
              OP_BEQ:       cur <= S_BRANCH;
              OP_J:         cur <= S_JUMP;
              OP_ADDI:      cur <= S_ADDI_EXEC;
              default:      cur <= S_FETCH;
            endcase
          end
        end
        // IR still holds the lw/sw opcode here
        S_MEM_ADDR:  cur <= (ctrl.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  cur <= ctrl.memReady ? S_MEM_WB : S_MEM_READ;
        S_MEM_WB:    cur <= S_FETCH;
        S_MEM_WRITE: cur <= ctrl.memReady ? S_FETCH : S_MEM_WRITE;
        S_R_EXEC:    cur <= S_R_WB;
        S_R_WB:      cur <= S_FETCH;
        S_BRANCH:    cur <= S_FETCH;
        S_JUMP:      cur <= S_FETCH;
        S_ADDI_EXEC: cur <= S_ADDI_WB;
        S_ADDI_WB:   cur <= S_FETCH;
        default:     cur <= S_IDLE;
      endcase
    end
  end

  // Control-line decode; every line defaults to 0 so IDLE drives nothing
  always_comb begin
    ctrl.PCWrite     = 1'b0;
    ctrl.PCWriteCond = 1'b0;
    ctrl.IorD        = 1'b0;
    ctrl.MemRead     = 1'b0;
    ctrl.MemWrite    = 1'b0;
    ctrl.IRWrite     = 1'b0;
    ctrl.MemtoReg    = 1'b0;
    ctrl.PCSource    = PCSRC_ALU;
    ctrl.ALUOp       = ALU_ADD;
    ctrl.ALUSrcA     = 1'b0;
    ctrl.ALUSrcB     = SRCB_REGB;
    ctrl.RegWrite    = 1'b0;
    ctrl.RegDst      = 1'b0;
    illegalOp        = 1'b0;
    case (cur)
      S_FETCH: begin
        ctrl.MemRead = 1'b1;
        ctrl.ALUSrcB = SRCB_FOUR;
        ctrl.IRWrite = ctrl.memReady;
        ctrl.PCWrite = ctrl.memReady;
      end
      S_DECODE: begin
        ctrl.ALUSrcB = SRCB_IMM_SH2;
        illegalOp    = !op_supported(ctrl.opcode, ENABLE_ADDI);
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUSrcB = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl.MemRead = 1'b1;
        ctrl.IorD    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.MemtoReg = 1'b1;
        ctrl.RegWrite = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.MemWrite = 1'b1;
        ctrl.IorD     = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUOp   = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.RegDst   = 1'b1;
        ctrl.RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.ALUSrcA     = 1'b1;
        ctrl.ALUOp       = ALU_SUB;
        ctrl.PCWriteCond = 1'b1;
        ctrl.PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.PCWrite  = 1'b1;
        ctrl.PCSource = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        ctrl.RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = STATE_W'(cur);

endmodule
